instr_issue: RTL and testbench
==============================

INSTR_ISSUE -- requirements
Module: instr_issue

Interface
REQ-001 Parameter LANES, default GPU_Shader_pkg::lanes, number of shader lanes fed.
REQ-002 Parameter DEPTH, default 4, instruction queue entries (power of 2, >=2).
REQ-003 Parameter PC_W, default 10, instruction address width.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse; begin fetching at start_pc (honoured only in IDLE or HALTED).
REQ-007 start_pc  in  PC_W  first instruction address.
REQ-008 imem_req / imem_addr  out  1 / PC_W  fetch request and word address.
REQ-009 imem_gnt  in  1  request accepted this cycle.
REQ-010 imem_rvalid / imem_rdata  in  1 / 32  read data return, >=1 cycle after gnt.
REQ-011 issue_valid  out  1  issue_instr holds a valid instruction.
REQ-012 issue_ready  in  1  shader consumes instruction when valid&ready.
REQ-013 issue_instr  out  32 x LANES  same instruction broadcast to every lane.
REQ-014 busy / halted  out  1 / 1  status flags.

Function
REQ-015 Instruction format: [31:26] opcode, [25:21] dst, [20:16] src0, [15:5] src1/immd low bits per package; only opcode is inspected here.
REQ-016 FSM states IDLE, FETCH, DRAIN, HALTED; reset state IDLE.
REQ-017 IDLE/HALTED + start -> FETCH, pc<=start_pc, queue flushed, halted<=0.
REQ-018 FETCH: imem_req=1 when no request outstanding and (count + outstanding) < DEPTH; imem_addr=pc.
REQ-019 imem_req and imem_addr held stable until imem_gnt; on gnt pc<=pc+1 (wraps modulo 2^PC_W), outstanding<=1.
REQ-020 At most one outstanding request; imem_rvalid clears outstanding and writes imem_rdata into the queue in the same cycle.
REQ-021 Returned word with opcode == OP_HALT (6'h3F) is not enqueued; FSM -> DRAIN, no further requests.
REQ-022 DRAIN -> HALTED when queue empty and issue side idle; halted=1 in HALTED only.
REQ-023 issue_valid = queue not empty; issue_instr = queue head on all lanes; head pops on valid&ready.
REQ-024 Simultaneous enqueue and pop with queue full or empty is legal; count unchanged, ordering preserved.
REQ-025 Latency: rvalid in cycle N -> issue_valid in cycle N+1 (registered queue, no bypass).
REQ-026 start while in FETCH or DRAIN is ignored.
REQ-027 Queue never overflows; imem_rvalid with no outstanding request is ignored.
REQ-028 busy=1 in FETCH and DRAIN, 0 otherwise.

Reset
REQ-029 rst_n low asynchronously forces IDLE, pc=0, count=0, outstanding=0, imem_req=0, imem_addr=0, issue_valid=0, issue_instr=0, busy=0, halted=0.
REQ-030 Reset mid-fetch drops the outstanding request; a late imem_rvalid after reset is ignored.
REQ-031 Reset release takes effect on the first rising edge after rst_n high; no output changes before it.

Structure
REQ-032 OP_HALT, opcode field positions, and lanes belong in GPU_Shader_pkg / opcode_pkg; FSM state enum in GPU_Shader_pkg.
REQ-033 One sub-module: instr_fifo (parameterised DEPTH x 32, push/pop/full/empty/count).

Verification
REQ-034 Reset then start pulse, start_pc=0x010, mem returns 1 cycle after gnt, ready=1 -> addresses 0x010,0x011,... issued in order, first issue_valid 2 cycles after first gnt.
REQ-035 issue_ready=0 throughout fetch -> exactly DEPTH entries queued, imem_req stays 0, no instruction lost when ready rises.
REQ-036 HALT word at 0x013 -> three instructions issued, HALT never on issue_instr, halted=1 after last pop, busy=0.
REQ-037 start_pc=0x3FE, PC_W=10 -> fetch addresses 0x3FE,0x3FF,0x000.
REQ-038 rst_n low while request outstanding, rvalid arrives during reset -> all outputs at reset values, queue empty after release.
REQ-039 Random gnt/rvalid/ready delays (0-5 cycles), 1000 instructions -> issued stream equals memory contents in order, every lane identical.

Source files
------------

// File: rtl/GPU_Shader_pkg.sv
`default_nettype none
// GPU_Shader_pkg: lane count, instruction field layout, opcodes and issue FSM states.
// Rev 1.0
package GPU_Shader_pkg;

  localparam int lanes = 4;

  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 26;
  localparam int DST_MSB  = 25;
  localparam int DST_LSB  = 21;
  localparam int SRC0_MSB = 20;
  localparam int SRC0_LSB = 16;
  localparam int SRC1_MSB = 15;
  localparam int SRC1_LSB = 5;

  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } issue_state_e;

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// instr_fifo: registered DEPTH x WIDTH instruction queue with flush, push/pop and occupancy count.
// Rev 1.0
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == CW'(DEPTH));
  assign w_do_pop  = pop && !empty;
  // A push into a full queue is accepted when the head leaves in the same cycle.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !flush) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_issue.sv
`default_nettype none
// instr_issue: fetches instruction words into a small queue and broadcasts the head to all shader lanes.
// Rev 1.0
module instr_issue
  import GPU_Shader_pkg::*;
#(
  parameter int LANES = GPU_Shader_pkg::lanes,
  parameter int DEPTH = 4,
  parameter int PC_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [PC_W-1:0]       start_pc,
  output logic                  imem_req,
  output logic [PC_W-1:0]       imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [LANES-1:0][31:0] issue_instr,
  output logic                  busy,
  output logic                  halted
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  issue_state_e    r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_outstanding;
  logic            r_busy;
  logic            r_halted;

  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_inflight;
  logic            w_full;
  logic            w_empty;
  logic [31:0]     w_head;
  logic            w_start_ok;
  logic            w_gnt;
  logic            w_rsp;
  logic            w_is_halt;
  logic            w_push;
  logic            w_pop;

  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_HALTED));
  assign w_inflight = w_count + CW'(r_outstanding);
  assign imem_req   = (r_state == ST_FETCH) && !r_outstanding && (w_inflight < C_DEPTH);
  assign imem_addr  = r_pc;
  assign w_gnt      = imem_req && imem_gnt;
  // Returns only count against a live request; stray or post-reset data is dropped.
  assign w_rsp      = imem_rvalid && r_outstanding && (r_state == ST_FETCH);
  assign w_is_halt  = (imem_rdata[OPC_MSB:OPC_LSB] == OP_HALT);
  assign w_push     = w_rsp && !w_is_halt && !w_full;
  assign w_pop      = issue_valid && issue_ready;

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (w_start_ok),
    .push  (w_push),
    .wdata (imem_rdata),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= '0;
      r_outstanding <= 1'b0;
      r_busy        <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_HALTED: begin
          if (start) begin
            r_state       <= ST_FETCH;
            r_pc          <= start_pc;
            r_outstanding <= 1'b0;
            r_busy        <= 1'b1;
            r_halted      <= 1'b0;
          end
        end
        ST_FETCH: begin
          if (w_gnt) begin
            r_pc          <= r_pc + PC_W'(1);
            r_outstanding <= 1'b1;
          end
          if (w_rsp) begin
            r_outstanding <= 1'b0;
            if (w_is_halt) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_empty) begin
            r_state  <= ST_HALTED;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign issue_valid = !w_empty;
  assign busy        = r_busy;
  assign halted      = r_halted;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign issue_instr[g] = w_empty ? 32'h0 : w_head;
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_issue.sv
`default_nettype none
// tb_instr_issue: memory/grant responder, issue-side scoreboard and directed scenarios for instr_issue.
// Rev 1.0
module tb_instr_issue;
  import GPU_Shader_pkg::*;

  localparam int LANES = lanes;
  localparam int DEPTH = 4;
  localparam int PC_W  = 10;
  localparam int MEMSZ = 1 << PC_W;

  typedef logic [LANES*32-1:0] vec_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   start = 1'b0;
  logic [PC_W-1:0]        start_pc = '0;
  logic                   imem_req;
  logic [PC_W-1:0]        imem_addr;
  logic                   imem_gnt = 1'b0;
  logic                   imem_rvalid = 1'b0;
  logic [31:0]            imem_rdata = '0;
  logic                   issue_valid;
  logic                   issue_ready = 1'b0;
  logic [LANES-1:0][31:0] issue_instr;
  logic                   busy;
  logic                   halted;

  instr_issue #(
    .LANES (LANES),
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .start_pc    (start_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_instr (issue_instr),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [MEMSZ];
  logic [31:0] exp_q [$];

  function automatic logic [31:0] gen_word(input int a);
    logic [9:0] aa;
    aa = 10'(a);
    return {1'b0, aa[4:0], aa ^ 10'h2A5, 16'(a * 37 + 5)};
  endfunction

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: grant after 0..gnt_max cycles, return data rsp_min..rsp_max cycles later.
  int              gnt_wait = 0;
  int              gnt_max  = 0;
  int              rsp_min  = 1;
  int              rsp_max  = 1;
  int              rsp_cnt  = 0;
  bit              rsp_pend = 1'b0;
  bit              stray    = 1'b0;
  logic [31:0]     rsp_word = '0;
  logic [PC_W-1:0] exp_addr = '0;
  int              n_gnt    = 0;
  int              first_gnt = -1;

  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (rsp_pend) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = rsp_word;
        rsp_pend    = 1'b0;
      end
    end else if (stray) begin
      imem_rvalid = 1'b1;
      imem_rdata  = gen_word(5);
      stray       = 1'b0;
    end
    imem_gnt = 1'b0;
    if (imem_req === 1'b1) begin
      if (gnt_wait > 0) gnt_wait--;
      else begin
        imem_gnt = 1'b1;
        check("imem_addr", vec_t'(imem_addr), vec_t'(exp_addr));
        rsp_word = mem[imem_addr];
        rsp_cnt  = int'($urandom_range(rsp_max, rsp_min));
        rsp_pend = 1'b1;
        exp_addr = exp_addr + PC_W'(1);
        n_gnt++;
        if (first_gnt < 0) first_gnt = cyc;
        gnt_wait = int'($urandom_range(gnt_max, 0));
      end
    end
  end

  // Issue side: drive ready, pop scoreboard on every accepted instruction.
  int ready_mode  = 0;
  int n_pop       = 0;
  int first_valid = -1;

  always @(negedge clk) begin
    logic [31:0] w;
    case (ready_mode)
      0:       issue_ready = 1'b0;
      1:       issue_ready = 1'b1;
      default: issue_ready = 1'($urandom_range(1, 0));
    endcase
    if (issue_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    if (issue_valid === 1'b1 && issue_ready) begin
      n_pop++;
      if (exp_q.size() == 0) begin
        check("issue_unexpected", vec_t'(issue_valid), vec_t'(0));
      end else begin
        w = exp_q.pop_front();
        check("issue_instr", vec_t'(issue_instr), {LANES{w}});
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},    vec_t'(imem_req),    vec_t'(0));
    check({tag, "_addr"},   vec_t'(imem_addr),   vec_t'(0));
    check({tag, "_valid"},  vec_t'(issue_valid), vec_t'(0));
    check({tag, "_instr"},  vec_t'(issue_instr), vec_t'(0));
    check({tag, "_busy"},   vec_t'(busy),        vec_t'(0));
    check({tag, "_halted"}, vec_t'(halted),      vec_t'(0));
  endtask

  task automatic do_start(input logic [PC_W-1:0] pc);
    start_pc = pc;
    exp_addr = pc;
    n_gnt    = 0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic wait_halted(input int limit);
    int k;
    k = 0;
    while (halted !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("halt_timeout", vec_t'(halted), vec_t'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < MEMSZ; a++) mem[a] = gen_word(a);

    // Reset values, asserted before any clock edge
    #2;
    check_reset_outputs("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", vec_t'(busy), vec_t'(0));

    // Basic fetch with HALT at 0x013, one-cycle memory, ready held high
    mem[10'h013] = {OP_HALT, 26'h0};
    ready_mode = 1; gnt_max = 0; rsp_min = 1; rsp_max = 1;
    for (int a = 16; a < 19; a++) exp_q.push_back(mem[a]);
    do_start(10'h010);
    check("fetch_busy",   vec_t'(busy),   vec_t'(1));
    check("fetch_halted", vec_t'(halted), vec_t'(0));
    wait_halted(200);
    check("t1_latency", vec_t'(first_valid - first_gnt), vec_t'(2));
    check("t1_gnts",    vec_t'(n_gnt),        vec_t'(4));
    check("t1_pops",    vec_t'(n_pop),        vec_t'(3));
    check("t1_left",    vec_t'(exp_q.size()), vec_t'(0));
    check("t1_busy",    vec_t'(busy),         vec_t'(0));
    @(negedge clk);
    check("t1_req_idle", vec_t'(imem_req), vec_t'(0));
    mem[10'h013] = gen_word(10'h013);

    // Back-pressure: queue fills to DEPTH, start in FETCH is ignored
    mem[10'h108] = {OP_HALT, 26'h0};
    ready_mode = 0; gnt_max = 2; rsp_min = 1; rsp_max = 3;
    for (int a = 10'h100; a < 10'h108; a++) exp_q.push_back(mem[a]);
    do_start(10'h100);
    repeat (4) @(negedge clk);
    start_pc = 10'h2AA;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    repeat (30) @(negedge clk);
    check("bp_valid", vec_t'(issue_valid), vec_t'(1));
    check("bp_req",   vec_t'(imem_req),    vec_t'(0));
    check("bp_gnts",  vec_t'(n_gnt),       vec_t'(DEPTH));
    check("bp_busy",  vec_t'(busy),        vec_t'(1));
    ready_mode = 1;
    wait_halted(300);
    check("bp_left", vec_t'(exp_q.size()), vec_t'(0));
    check("bp_total_gnts", vec_t'(n_gnt), vec_t'(9));
    mem[10'h108] = gen_word(10'h108);

    // PC wrap at 2^PC_W
    mem[10'h001] = {OP_HALT, 26'h0};
    ready_mode = 2; gnt_max = 1; rsp_min = 1; rsp_max = 2;
    exp_q.push_back(mem[10'h3FE]);
    exp_q.push_back(mem[10'h3FF]);
    exp_q.push_back(mem[10'h000]);
    do_start(10'h3FE);
    wait_halted(300);
    check("wrap_left", vec_t'(exp_q.size()), vec_t'(0));
    check("wrap_gnts", vec_t'(n_gnt),        vec_t'(4));
    mem[10'h001] = gen_word(10'h001);

    // Reset with a request outstanding; data returns while reset is held
    ready_mode = 0; gnt_max = 0; rsp_min = 4; rsp_max = 4;
    do_start(10'h200);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    repeat (6) @(negedge clk);
    check("rst_rsp_seen", vec_t'(rsp_pend), vec_t'(0));
    check_reset_outputs("held_rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("post_rst");
    check("rst_gnts", vec_t'(n_gnt), vec_t'(1));

    // Stray read data with nothing outstanding
    stray = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_valid", vec_t'(issue_valid), vec_t'(0));
    check("stray_busy",  vec_t'(busy),        vec_t'(0));

    // Long random-latency stream of 1000 instructions
    mem[10'h010 + 1000] = {OP_HALT, 26'h0};
    ready_mode = 2; gnt_max = 5; rsp_min = 1; rsp_max = 5;
    for (int a = 10'h010; a < 10'h010 + 1000; a++) exp_q.push_back(mem[a]);
    do_start(10'h010);
    wait_halted(40000);
    check("rnd_left", vec_t'(exp_q.size()), vec_t'(0));
    check("rnd_gnts", vec_t'(n_gnt),        vec_t'(1001));
    check("rnd_busy", vec_t'(busy),         vec_t'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
